// File: rtl/match_control_if.sv
// Match controller I/O bundle: menu key, hit/shield strobes in, and the
// match status (state, HP, rounds, invulnerability, round pulse) out.
// The slave modport is the controller side; master is the game logic
// that feeds strobes and consumes status.
interface match_control_if #(
    parameter int HP_W = 2,
    parameter int RW   = 2
);
    logic            select;
    logic            player_hit;
    logic            enemy_hit;
    logic            player_shield;
    logic            enemy_shield;
    logic [2:0]      o_state;
    logic            o_is_gaming;
    logic [HP_W-1:0] o_player_hp;
    logic [HP_W-1:0] o_enemy_hp;
    logic [RW-1:0]   o_player_rounds;
    logic [RW-1:0]   o_enemy_rounds;
    logic            o_player_invuln;
    logic            o_enemy_invuln;
    logic            o_round_done;

    modport master (
        output select, player_hit, enemy_hit, player_shield, enemy_shield,
        input  o_state, o_is_gaming, o_player_hp, o_enemy_hp,
               o_player_rounds, o_enemy_rounds,
               o_player_invuln, o_enemy_invuln, o_round_done
    );

    modport slave (
        input  select, player_hit, enemy_hit, player_shield, enemy_shield,
        output o_state, o_is_gaming, o_player_hp, o_enemy_hp,
               o_player_rounds, o_enemy_rounds,
               o_player_invuln, o_enemy_invuln, o_round_done
    );
endinterface

// File: rtl/match_control.sv
// Best-of-N fighting-game match controller: menu start, HP bookkeeping with
// invulnerability frames, round pause, and win/lose screens.
// Optional feature: define MATCH_CONTROL_TIMEOUT_EN to add a per-round time
// limit (ROUND_TIME_CYCLES); on expiry the side with more HP takes the round.
module match_control #(
    parameter int HP_W             = 2,
    parameter int HP_INIT          = 3,
    parameter int ROUNDS_TO_WIN    = 2,
    parameter int IFRAME_CYCLES    = 4,
    parameter int ROUND_END_CYCLES = 8
`ifdef MATCH_CONTROL_TIMEOUT_EN
    ,
    parameter int ROUND_TIME_CYCLES = 1024
`endif
) (
    input logic            clk,
    input logic            rst,
    match_control_if.slave bus
);
    localparam int RW = $clog2(ROUNDS_TO_WIN + 1);
    localparam int IW = (IFRAME_CYCLES > 0) ? $clog2(IFRAME_CYCLES + 1) : 1;
    localparam int TW = $clog2(ROUND_END_CYCLES + 1);
`ifdef MATCH_CONTROL_TIMEOUT_EN
    localparam int RTW = $clog2(ROUND_TIME_CYCLES + 1);
`endif

    typedef enum logic [2:0] {
        S_START     = 3'd0,
        S_PLAY      = 3'd1,
        S_ROUND_END = 3'd2,
        S_WIN       = 3'd3,
        S_LOSE      = 3'd4
    } state_t;

    state_t          state;
    logic            select_q;
    logic [HP_W-1:0] p_hp, e_hp;
    logic [RW-1:0]   p_rounds, e_rounds;
    logic [IW-1:0]   p_inv, e_inv;
    logic [TW-1:0]   timer;
    logic            round_done;
`ifdef MATCH_CONTROL_TIMEOUT_EN
    logic [RTW-1:0]  round_timer;
`endif

    logic sel_rise;
    logic p_hit_ok, e_hit_ok;
    logic end_round, award_p, award_e;

    assign sel_rise = bus.select & ~select_q;

    // Decide which hits count this cycle and whether the round is over.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
        p_hit_ok  = bus.player_hit && !bus.player_shield && (p_inv == '0) && (p_hp != '0);
        e_hit_ok  = bus.enemy_hit  && !bus.enemy_shield  && (e_inv == '0) && (e_hp != '0);
        end_round = 1'b0;
        award_p   = 1'b0;
        award_e   = 1'b0;
        if ((p_hp == '0) || (e_hp == '0)) begin
            end_round = 1'b1;
            award_p   = (e_hp == '0) && (p_hp != '0);
            award_e   = (p_hp == '0) && (e_hp != '0);
        end
`ifdef MATCH_CONTROL_TIMEOUT_EN
        else if (round_timer == RTW'(ROUND_TIME_CYCLES - 1)) begin
            end_round = 1'b1;
            award_p   = p_hp > e_hp;
            award_e   = e_hp > p_hp;
        end
`endif
    end

    // Match FSM and all datapath registers, with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every register samples the pre-edge values.
        if (rst) begin
            state      <= S_START;
            select_q   <= 1'b1;
            p_hp       <= HP_W'(HP_INIT);
            e_hp       <= HP_W'(HP_INIT);
            p_rounds   <= '0;
            e_rounds   <= '0;
            p_inv      <= '0;
            e_inv      <= '0;
            timer      <= '0;
            round_done <= 1'b0;
`ifdef MATCH_CONTROL_TIMEOUT_EN
            round_timer <= '0;
`endif
        end else begin
            select_q   <= bus.select;
            round_done <= 1'b0;
            case (state)
                S_START: begin
                    if (sel_rise) begin
                        state    <= S_PLAY;
                        p_hp     <= HP_W'(HP_INIT);
                        e_hp     <= HP_W'(HP_INIT);
                        p_rounds <= '0;
                        e_rounds <= '0;
                        p_inv    <= '0;
                        e_inv    <= '0;
`ifdef MATCH_CONTROL_TIMEOUT_EN
                        round_timer <= '0;
`endif
                    end
                end
                S_PLAY: begin
                    if (p_hit_ok) begin
                        p_hp  <= p_hp - HP_W'(1);
                        p_inv <= IW'(IFRAME_CYCLES);
                    end else if (p_inv != '0) begin
                        p_inv <= p_inv - IW'(1);
                    end
                    if (e_hit_ok) begin
                        e_hp  <= e_hp - HP_W'(1);
                        e_inv <= IW'(IFRAME_CYCLES);
                    end else if (e_inv != '0) begin
                        e_inv <= e_inv - IW'(1);
                    end
                    if (end_round) begin
                        state      <= S_ROUND_END;
                        timer      <= '0;
                        round_done <= 1'b1;
                        if (award_p && (p_rounds != RW'(ROUNDS_TO_WIN)))
                            p_rounds <= p_rounds + RW'(1);
                        if (award_e && (e_rounds != RW'(ROUNDS_TO_WIN)))
                            e_rounds <= e_rounds + RW'(1);
                    end
`ifdef MATCH_CONTROL_TIMEOUT_EN
                    else begin
                        round_timer <= round_timer + RTW'(1);
                    end
`endif
                end
                S_ROUND_END: begin
                    if (timer == TW'(ROUND_END_CYCLES - 1)) begin
                        if (p_rounds == RW'(ROUNDS_TO_WIN)) begin
                            state <= S_WIN;
                        end else if (e_rounds == RW'(ROUNDS_TO_WIN)) begin
                            state <= S_LOSE;
                        end else begin
                            state <= S_PLAY;
                            p_hp  <= HP_W'(HP_INIT);
                            e_hp  <= HP_W'(HP_INIT);
                            p_inv <= '0;
                            e_inv <= '0;
`ifdef MATCH_CONTROL_TIMEOUT_EN
                            round_timer <= '0;
`endif
                        end
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                S_WIN, S_LOSE: begin
                    if (sel_rise)
                        state <= S_START;
                end
                default: state <= S_START;
            endcase
        end
    end

    assign bus.o_state         = state;
    assign bus.o_is_gaming     = (state == S_PLAY);
    assign bus.o_player_hp     = p_hp;
    assign bus.o_enemy_hp      = e_hp;
    assign bus.o_player_rounds = p_rounds;
    assign bus.o_enemy_rounds  = e_rounds;
    assign bus.o_player_invuln = (p_inv != '0);
    assign bus.o_enemy_invuln  = (e_inv != '0);
    assign bus.o_round_done    = round_done;
endmodule

// File: tb/tb_match_control.sv
// Bench for match_control: directed match scenarios followed by randomized
// play, every cycle compared against a behavioural match model.
module tb_match_control;
    localparam int HP_W             = 2;
    localparam int HP_INIT          = 3;
    localparam int ROUNDS_TO_WIN    = 2;
    localparam int IFRAME_CYCLES    = 4;
    localparam int ROUND_END_CYCLES = 8;
    localparam int RW               = $clog2(ROUNDS_TO_WIN + 1);
`ifdef MATCH_CONTROL_TIMEOUT_EN
    localparam int ROUND_TIME_CYCLES = 1024;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    match_control_if #(.HP_W(HP_W), .RW(RW)) bus ();

    match_control #(
        .HP_W(HP_W), .HP_INIT(HP_INIT), .ROUNDS_TO_WIN(ROUNDS_TO_WIN),
        .IFRAME_CYCLES(IFRAME_CYCLES), .ROUND_END_CYCLES(ROUND_END_CYCLES)
`ifdef MATCH_CONTROL_TIMEOUT_EN
        , .ROUND_TIME_CYCLES(ROUND_TIME_CYCLES)
`endif
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: states by their spec codes, pause as cycles remaining.
    int m_state, m_php, m_ehp, m_pr, m_er, m_pinv, m_einv, m_pause, m_age;
    bit m_sel_q, m_done;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int sat_inc(input int v);
        return (v < ROUNDS_TO_WIN) ? v + 1 : ROUNDS_TO_WIN;
    endfunction

    task automatic model_new_round();
        m_php  = HP_INIT;
        m_ehp  = HP_INIT;
        m_pinv = 0;
        m_einv = 0;
        m_age  = 0;
    endtask

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic model_step();
        bit rise, p_cnt, e_cnt, timeout;
        int old_p, old_e;
        if (rst) begin
            m_state = 0; m_sel_q = 1'b1; m_done = 1'b0; m_pause = 0;
            m_pr = 0; m_er = 0;
            model_new_round();
            return;
        end
        rise    = bus.select && !m_sel_q;
        m_sel_q = bus.select;
        m_done  = 1'b0;
        case (m_state)
            0: if (rise) begin
                m_state = 1; m_pr = 0; m_er = 0;
                model_new_round();
            end
            1: begin
                old_p = m_php;
                old_e = m_ehp;
                p_cnt = bus.player_hit && !bus.player_shield && m_pinv == 0 && m_php > 0;
                e_cnt = bus.enemy_hit  && !bus.enemy_shield  && m_einv == 0 && m_ehp > 0;
                if (p_cnt) begin m_php--; m_pinv = IFRAME_CYCLES; end
                else if (m_pinv > 0) m_pinv--;
                if (e_cnt) begin m_ehp--; m_einv = IFRAME_CYCLES; end
                else if (m_einv > 0) m_einv--;
                timeout = 1'b0;
`ifdef MATCH_CONTROL_TIMEOUT_EN
                timeout = (m_age + 1 == ROUND_TIME_CYCLES);
`endif
                if (old_p == 0 || old_e == 0) begin
                    m_state = 2; m_pause = ROUND_END_CYCLES; m_done = 1'b1;
                    if (old_e == 0 && old_p != 0) m_pr = sat_inc(m_pr);
                    if (old_p == 0 && old_e != 0) m_er = sat_inc(m_er);
                end else if (timeout) begin
                    m_state = 2; m_pause = ROUND_END_CYCLES; m_done = 1'b1;
                    if (old_p > old_e) m_pr = sat_inc(m_pr);
                    if (old_e > old_p) m_er = sat_inc(m_er);
                end else begin
                    m_age++;
                end
            end
            2: if (m_pause == 1) begin
                if (m_pr == ROUNDS_TO_WIN) m_state = 3;
                else if (m_er == ROUNDS_TO_WIN) m_state = 4;
                else begin m_state = 1; m_php = HP_INIT; m_ehp = HP_INIT; m_pinv = 0; m_einv = 0; m_age = 0; end
            end else begin
                m_pause--;
            end
            3, 4: if (rise) m_state = 0;
            default: m_state = 0;
        endcase
    endtask

    task automatic compare_all();
        check("state",     bus.o_state,         m_state);
        check("is_gaming", bus.o_is_gaming,     m_state == 1);
        check("player_hp", bus.o_player_hp,     m_php);
        check("enemy_hp",  bus.o_enemy_hp,      m_ehp);
        check("p_rounds",  bus.o_player_rounds, m_pr);
        check("e_rounds",  bus.o_enemy_rounds,  m_er);
        check("p_invuln",  bus.o_player_invuln, m_pinv != 0);
        check("e_invuln",  bus.o_enemy_invuln,  m_einv != 0);
        check("round_done", bus.o_round_done,   m_done);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic drive(input bit sel, input bit ph, input bit eh, input bit ps, input bit es);
        bus.select        = sel;
        bus.player_hit    = ph;
        bus.enemy_hit     = eh;
        bus.player_shield = ps;
        bus.enemy_shield  = es;
    endtask

    initial begin
        int n_trans, n_chg, last_chg, prev_hp, n_pulse, n_re, n_inv;
        drive(1, 0, 0, 0, 0);
        rst = 1'b1;

        // Key held through reset must not start a match.
        repeat (3) tick();
        rst = 1'b0;
        repeat (3) tick();
        check("held_key_no_start", bus.o_state, 0);

        // Release then hold select for 10 cycles: exactly one start.
        drive(0, 0, 0, 0, 0);
        tick();
        drive(1, 0, 0, 0, 0);
        n_trans = 0;
        for (int i = 0; i < 10; i++) begin
            logic [2:0] prev;
            prev = bus.o_state;
            tick();
            if (prev == 3'd0 && bus.o_state == 3'd1) n_trans++;
        end
        check("start_count", n_trans, 1);
        check("start_state", bus.o_state, 1);
        check("start_hp", {bus.o_player_hp, bus.o_enemy_hp}, {2'd3, 2'd3});
        drive(0, 0, 0, 0, 0);
        tick();

        // Enemy hit held 20 cycles: 3->2->1->0 at 5-cycle spacing, then pause.
        drive(0, 0, 1, 0, 0);
        n_chg = 0; last_chg = 0; n_pulse = 0; n_re = 0;
        prev_hp = int'(bus.o_enemy_hp);
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (bus.o_state == 3'd1 && int'(bus.o_enemy_hp) != prev_hp && bus.o_enemy_hp != 2'd3) begin
                if (n_chg > 0) check("hit_spacing", c - last_chg, 5);
                n_chg++;
                last_chg = c;
            end
            prev_hp = int'(bus.o_enemy_hp);
            if (bus.o_round_done) n_pulse++;
            if (bus.o_state == 3'd2) n_re++;
            if (c == 12) check("round_end_entry", bus.o_state, 2);
        end
        check("hp_steps", n_chg, 3);
        check("done_pulses", n_pulse, 1);
        check("pause_len", n_re, ROUND_END_CYCLES);
        check("p_round_won", bus.o_player_rounds, 1);
        drive(0, 0, 0, 0, 0);

        // Shielded player hits do nothing.
        drive(0, 1, 0, 1, 0);
        n_inv = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.o_player_invuln) n_inv++;
        end
        check("shield_hp", bus.o_player_hp, 3);
        check("shield_invuln", n_inv, 0);

        // Bring both sides to HP 1, then a simultaneous kill is a draw.
        drive(0, 1, 1, 0, 0);
        repeat (6) tick();
        drive(0, 0, 0, 0, 0);
        repeat (5) tick();
        check("both_hp1", {bus.o_player_hp, bus.o_enemy_hp}, {2'd1, 2'd1});
        drive(0, 1, 1, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0);
        check("both_hp0", {bus.o_player_hp, bus.o_enemy_hp}, {2'd0, 2'd0});
        tick();
        check("draw_state", bus.o_state, 2);
        check("draw_rounds", {bus.o_player_rounds, bus.o_enemy_rounds}, {2'd1, 2'd0});
        repeat (7) tick();
        check("draw_pause", bus.o_state, 2);
        tick();
        check("draw_resume", bus.o_state, 1);
        check("draw_reload", {bus.o_player_hp, bus.o_enemy_hp}, {2'd3, 2'd3});

        // Player takes the second round and the match.
        drive(0, 0, 1, 0, 0);
        repeat (20) tick();
        check("win_state", bus.o_state, 3);
        check("win_rounds", bus.o_player_rounds, 2);
        drive(1, 0, 0, 0, 0);
        tick();
        check("win_to_start", bus.o_state, 0);
        check("start_hold_rounds", bus.o_player_rounds, 2);
        drive(0, 0, 0, 0, 0);
        tick();
        drive(1, 0, 0, 0, 0);
        tick();
        check("restart_rounds", {bus.o_player_rounds, bus.o_enemy_rounds}, {2'd0, 2'd0});
        drive(0, 0, 0, 0, 0);

        // Reset asserted in the middle of a pause.
        drive(0, 0, 1, 0, 0);
        repeat (13) tick();
        check("pre_rst_pause", bus.o_state, 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_state", bus.o_state, 0);
        check("rst_hp", {bus.o_player_hp, bus.o_enemy_hp}, {2'd3, 2'd3});
        check("rst_rounds", {bus.o_player_rounds, bus.o_enemy_rounds}, {2'd0, 2'd0});
        check("rst_misc", {bus.o_player_invuln, bus.o_enemy_invuln, bus.o_round_done}, 3'b000);

        // Randomized play against the model.
        for (int i = 0; i < 4000; i++) begin
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 3) == 0);
            rst = ($urandom_range(0, 499) == 0);
            tick();
        end
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
